// File: rtl/bf_pkg.sv
// +----------------------------------------------------------------------------+
// | bf_pkg - shared widths, codes and FSM encoding for the Bellman-Ford blocks |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bf_pkg;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam logic [DW-1:0] INF = 16'hFFFF;
  localparam logic [AW-1:0] ONE_AW = AW'(1);

  // Relax handshake bundle: node index width on the request side.
  localparam int RELAX_NODE_W = AW;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INIT       = 3'd1,
    ST_RELAX_REQ  = 3'd2,
    ST_RELAX_WAIT = 3'd3,
    ST_PASS_END   = 3'd4,
    ST_CHECK_REQ  = 3'd5,
    ST_CHECK_WAIT = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  function automatic logic is_active(input state_t s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bf_pass_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | bf_pass_scheduler_if - relax request/acknowledge handshake bundle          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface bf_pass_scheduler_if;
  import bf_pkg::*;

  logic                    relax_req;
  logic [RELAX_NODE_W-1:0] relax_node;
  logic                    relax_ack;
  logic                    relax_updated;

  modport master (
    output relax_req,
    output relax_node,
    input  relax_ack,
    input  relax_updated
  );

  modport slave (
    input  relax_req,
    input  relax_node,
    output relax_ack,
    output relax_updated
  );

endinterface

`default_nettype wire

// File: rtl/bf_node_counter.sv
// +----------------------------------------------------------------------------+
// | bf_node_counter - node index counter with clear, increment and last flag   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bf_node_counter
  import bf_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] num_nodes,
  output logic [AW-1:0] node,
  output logic          last
);

  always_ff @(posedge clock) begin
    if (reset) begin
      node <= '0;
    end else if (clear) begin
      node <= '0;
    end else if (inc) begin
      node <= node + ONE_AW;
    end
  end

  // Only consulted while a run with N >= 1 is active, so N-1 never wraps here.
  assign last = (node == (num_nodes - ONE_AW));

endmodule

`default_nettype wire

// File: rtl/bf_pass_scheduler.sv
// +----------------------------------------------------------------------------+
// | bf_pass_scheduler - initialises distances, sequences relax passes and the  |
// | final negative-cycle detection pass. Revision: 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module bf_pass_scheduler
  import bf_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [AW-1:0]              num_nodes,
  input  logic [AW-1:0]              src_node,
  output logic                       init_we,
  output logic [AW-1:0]              init_addr,
  output logic [DW-1:0]              init_data,
  bf_pass_scheduler_if.master        relax,
  output logic                       busy,
  output logic [AW-1:0]              pass_count,
  output logic                       Finish,
  output logic                       NegCycle
);

  state_t        state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] src_q, src_d;
  logic          changed_q, changed_d;
  logic [AW-1:0] pcount_q, pcount_d;
  logic          finish_q, finish_d;
  logic          neg_q, neg_d;
  logic          gap_q;
  logic          ack_ok;
  logic          req_c;
  logic          cnt_clear, cnt_inc;
  logic [AW-1:0] node;
  logic          last;

  bf_node_counter u_node_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .num_nodes (n_q),
    .node      (node),
    .last      (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      src_q     <= '0;
      changed_q <= 1'b0;
      pcount_q  <= '0;
      finish_q  <= 1'b0;
      neg_q     <= 1'b0;
      gap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      src_q     <= src_d;
      changed_q <= changed_d;
      pcount_q  <= pcount_d;
      finish_q  <= finish_d;
      neg_q     <= neg_d;
      gap_q     <= ack_ok;
    end
  end

  // gap_q holds the request low for one cycle after every accepted ack.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    src_d     = src_q;
    changed_d = changed_q;
    pcount_d  = pcount_q;
    finish_d  = finish_q;
    neg_d     = neg_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    req_c     = 1'b0;
    ack_ok    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d       = num_nodes;
          src_d     = src_node;
          pcount_d  = '0;
          finish_d  = 1'b0;
          neg_d     = 1'b0;
          cnt_clear = 1'b1;
          if (num_nodes == '0) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
          end else begin
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        if (last) begin
          cnt_clear = 1'b1;
          changed_d = 1'b0;
          state_d   = (n_q == ONE_AW) ? ST_CHECK_REQ : ST_RELAX_REQ;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RELAX_REQ: begin
        if (!gap_q) begin
          req_c   = 1'b1;
          state_d = ST_RELAX_WAIT;
        end
      end
      ST_RELAX_WAIT: begin
        req_c = 1'b1;
        if (relax.relax_ack) begin
          ack_ok    = 1'b1;
          changed_d = changed_q | relax.relax_updated;
          if (last) begin
            state_d = ST_PASS_END;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_RELAX_REQ;
          end
        end
      end
      ST_PASS_END: begin
        pcount_d  = pcount_q + ONE_AW;
        cnt_clear = 1'b1;
        if (!changed_q) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
        end else if (pcount_d == (n_q - ONE_AW)) begin
          state_d = ST_CHECK_REQ;
        end else begin
          changed_d = 1'b0;
          state_d   = ST_RELAX_REQ;
        end
      end
      ST_CHECK_REQ: begin
        if (!gap_q) begin
          req_c   = 1'b1;
          state_d = ST_CHECK_WAIT;
        end
      end
      ST_CHECK_WAIT: begin
        req_c = 1'b1;
        if (relax.relax_ack) begin
          ack_ok = 1'b1;
          if (relax.relax_updated) begin
            state_d = ST_DONE;
            neg_d   = 1'b1;
          end else if (last) begin
            state_d  = ST_DONE;
            finish_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_CHECK_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign init_we          = (state_q == ST_INIT);
  assign init_addr        = init_we ? node : '0;
  assign init_data        = (init_we && (node != src_q)) ? INF : '0;
  assign relax.relax_req  = req_c;
  assign relax.relax_node = node;
  assign busy             = is_active(state_q);
  assign pass_count       = pcount_q;
  assign Finish           = finish_q;
  assign NegCycle         = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_bf_pass_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_bf_pass_scheduler - vector table plus event scoreboard for the scheduler|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bf_pass_scheduler;
  import bf_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] num_nodes;
  logic [AW-1:0] src_node;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;
  logic          busy;
  logic [AW-1:0] pass_count;
  logic          Finish;
  logic          NegCycle;

  bf_pass_scheduler_if rif ();

  bf_pass_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_nodes  (num_nodes),
    .src_node   (src_node),
    .init_we    (init_we),
    .init_addr  (init_addr),
    .init_data  (init_data),
    .relax      (rif),
    .busy       (busy),
    .pass_count (pass_count),
    .Finish     (Finish),
    .NegCycle   (NegCycle)
  );

  always #5 clock = ~clock;

  typedef struct {
    int n; int src; int upd_first; int upd_rest; int delay;
    int spur; int midstart; int exp_fin; int exp_neg; int exp_pc;
  } vec_t;

  typedef struct {
    bit            kind;   // 0 = init write, 1 = relax request
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  ev_t  sb[$];
  vec_t vecs[9];
  int   checks = 0;
  int   errors = 0;

  int   rsp_delay = 0;
  int   rsp_upd_first = 0;
  int   rsp_upd_rest = 0;
  int   rsp_idx = 0;
  bit   rsp_spur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input bit kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected event: kind %0d addr %0h data %0h, expected none", kind, addr, data);
    end else begin
      e = sb.pop_front();
      check("event kind", 32'(kind), 32'(e.kind));
      check("event addr", 32'(addr), 32'(e.addr));
      if (!e.kind) check("init data", 32'(data), 32'(e.data));
    end
  endtask

  // Reference sequence of init writes and relax/check requests for one run.
  task automatic model_push(input int n, input int src, input int uf, input int ur);
    int ack = 0;
    int pc = 0;
    bit ch;
    bit u;
    bit stop = 1'b0;
    sb.delete();
    if (n == 0) return;
    for (int i = 0; i < n; i++)
      sb.push_back('{1'b0, AW'(i), (i == src) ? 16'h0000 : INF});
    while (n > 1 && !stop) begin
      ch = 1'b0;
      for (int k = 0; k < n; k++) begin
        sb.push_back('{1'b1, AW'(k), 16'h0000});
        u = (ack < uf) ? 1'b1 : ur[0];
        ack++;
        ch = ch | u;
      end
      pc++;
      if (!ch) return;
      if (pc == n - 1) stop = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      sb.push_back('{1'b1, AW'(k), 16'h0000});
      u = (ack < uf) ? 1'b1 : ur[0];
      ack++;
      if (u) return;
    end
  endtask

  // Relax engine model: acks (1 + rsp_delay) cycles after seeing the request.
  initial begin
    int hi = 0;
    rif.relax_ack = 1'b0;
    rif.relax_updated = 1'b0;
    forever begin
      @(negedge clock);
      if (rif.relax_ack) begin
        rif.relax_ack = 1'b0;
        rif.relax_updated = 1'b0;
      end else if (rif.relax_req) begin
        hi++;
        if (hi >= 2 + rsp_delay) begin
          rif.relax_ack = 1'b1;
          rif.relax_updated = (rsp_idx < rsp_upd_first) ? 1'b1 : rsp_upd_rest[0];
          rsp_idx++;
          hi = 0;
        end
      end else begin
        hi = 0;
        if (rsp_spur && busy) begin
          rif.relax_ack = 1'b1;
          rif.relax_updated = 1'b1;
          rsp_spur = 1'b0;
        end
      end
    end
  end

  // Output monitor: compares every DUT event against the scoreboard queue.
  initial begin
    bit            req_prev = 1'b0;
    logic [AW-1:0] node_hold = '0;
    forever begin
      @(negedge clock);
      if (init_we) sb_check(1'b0, init_addr, init_data);
      if (rif.relax_req && !req_prev) begin
        sb_check(1'b1, rif.relax_node, 16'h0000);
        node_hold = rif.relax_node;
      end else if (rif.relax_req) begin
        check("relax_node stable", 32'(rif.relax_node), 32'(node_hold));
      end
      req_prev = rif.relax_req;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, " init_we"},    32'(init_we),        32'(0));
    check({tag, " init_addr"},  32'(init_addr),      32'(0));
    check({tag, " init_data"},  32'(init_data),      32'(0));
    check({tag, " relax_req"},  32'(rif.relax_req),  32'(0));
    check({tag, " relax_node"}, 32'(rif.relax_node), 32'(0));
    check({tag, " busy"},       32'(busy),           32'(0));
    check({tag, " pass_count"}, 32'(pass_count),     32'(0));
    check({tag, " Finish"},     32'(Finish),         32'(0));
    check({tag, " NegCycle"},   32'(NegCycle),       32'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc = 0;
    int lat = -1;
    bit done = 1'b0;
    rsp_delay = v.delay;
    rsp_upd_first = v.upd_first;
    rsp_upd_rest = v.upd_rest;
    rsp_idx = 0;
    model_push(v.n, v.src, v.upd_first, v.upd_rest);
    @(negedge clock);
    start = 1'b1;
    num_nodes = AW'(v.n);
    src_node = AW'(v.src);
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    check({tag, " busy after start"}, 32'(busy), 32'(v.n != 0));
    if (v.n == 0) check({tag, " Finish next cycle"}, 32'(Finish), 32'(1));
    while (!done && cyc < 3000) begin
      if (rif.relax_req && lat < 0) lat = cyc;
      if (v.spur != 0 && cyc == 20) rsp_spur = 1'b1;
      if (v.midstart != 0 && cyc == 30) begin
        start = 1'b1;
        num_nodes = AW'(2);
        src_node = AW'(1);
      end else begin
        start = 1'b0;
      end
      if (!busy && (Finish || NegCycle)) begin
        done = 1'b1;
      end else begin
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, " completed in budget"}, 32'(done), 32'(1));
    if (v.n > 0) check({tag, " start to first req"}, 32'(lat), 32'(v.n + 1));
    check({tag, " Finish"},     32'(Finish),     32'(v.exp_fin));
    check({tag, " NegCycle"},   32'(NegCycle),   32'(v.exp_neg));
    check({tag, " pass_count"}, 32'(pass_count), 32'(v.exp_pc));
    check({tag, " events left"}, 32'(sb.size()), 32'(0));
    repeat (2) @(negedge clock);
    check({tag, " Finish held"},     32'(Finish),     32'(v.exp_fin));
    check({tag, " NegCycle held"},   32'(NegCycle),   32'(v.exp_neg));
    check({tag, " pass_count held"}, 32'(pass_count), 32'(v.exp_pc));
    check({tag, " busy done"},       32'(busy),       32'(0));
    check({tag, " init_data idle"},  32'(init_data),  32'(0));
  endtask

  initial begin
    int   w;
    vec_t rv;
    //          n  src  uf    ur dly spur mid fin neg pc
    vecs[0] = '{4, 2,   4,    0, 0,  0,   0,  1,  0,  2};
    vecs[1] = '{3, 0,   1000, 1, 0,  0,   0,  0,  1,  2};
    vecs[2] = '{0, 0,   0,    0, 0,  0,   0,  1,  0,  0};
    vecs[3] = '{1, 0,   0,    0, 0,  0,   0,  1,  0,  0};
    vecs[4] = '{1, 0,   0,    1, 0,  0,   0,  0,  1,  0};
    vecs[5] = '{5, 7,   0,    0, 0,  0,   0,  1,  0,  1};
    vecs[6] = '{3, 1,   6,    0, 1,  0,   0,  1,  0,  2};
    vecs[7] = '{2, 1,   2,    1, 0,  0,   0,  0,  1,  1};
    vecs[8] = '{4, 0,   4,    0, 5,  1,   1,  1,  0,  2};

    reset = 1'b1;
    start = 1'b0;
    num_nodes = '0;
    src_node = '0;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort during the second pass, then a clean N=2 run must still work.
    rsp_delay = 3;
    rsp_upd_first = 1000;
    rsp_upd_rest = 1;
    rsp_idx = 0;
    model_push(4, 0, 1000, 1);
    @(negedge clock);
    start = 1'b1;
    num_nodes = AW'(4);
    src_node = AW'(0);
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (!(pass_count == AW'(1) && rif.relax_req) && w < 1000) begin
      @(negedge clock);
      w++;
    end
    check("abort reached pass 2 wait", 32'(w < 1000), 32'(1));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_zero("abort");
    reset = 1'b0;
    sb.delete();
    rv = '{2, 0, 2, 0, 0, 0, 0, 1, 0, 1};
    run_vec(rv, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
